// File: rtl/sme_param.sv
// sme_param: string-match engine.
// Loads one string and one pattern, then scans the string one start position per cycle and
// reports the first match with a single-cycle valid strobe. Pattern meta characters: '^' (as
// the first char), '$' (as the last char) and '.' (any char).
// Optional feature macro SME_STAR_EN: one '*' splits the pattern into a prefix and a suffix.
// The earliest prefix hit is located first, then the suffix is searched from the end of that
// prefix onward. With the macro undefined, '*' is an ordinary literal.
module sme_param #(
    parameter int unsigned CHAR_W    = 8,
    parameter int unsigned STR_DEPTH = 32,
    parameter int unsigned PAT_DEPTH = 8,
    localparam int unsigned IDX_W    = $clog2(STR_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    output logic              busy,
    output logic              valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index
);

    // String lengths and all index sums are one bit wider than IDX_W so that str_len can
    // reach STR_DEPTH and end-of-string tests never wrap.
    localparam int unsigned LEN_W  = IDX_W + 1;
    localparam int unsigned PIDX_W = $clog2(PAT_DEPTH);
    localparam int unsigned PLEN_W = $clog2(PAT_DEPTH + 1);

    localparam logic [CHAR_W-1:0] CH_CARET  = CHAR_W'(8'h5E);
    localparam logic [CHAR_W-1:0] CH_DOLLAR = CHAR_W'(8'h24);
    localparam logic [CHAR_W-1:0] CH_DOT    = CHAR_W'(8'h2E);
    localparam logic [CHAR_W-1:0] CH_SPACE  = CHAR_W'(8'h20);
`ifdef SME_STAR_EN
    localparam logic [CHAR_W-1:0] CH_STAR   = CHAR_W'(8'h2A);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StLoadStr,
        StLoadPat,
        StScan,
`ifdef SME_STAR_EN
        StScanSuf,
`endif
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CHAR_W-1:0] str_q [STR_DEPTH];
    logic [CHAR_W-1:0] pat_q [PAT_DEPTH];

    logic [LEN_W-1:0]  str_len_q, str_len_d;
    logic [PLEN_W-1:0] pat_len_q, pat_len_d;
    logic [LEN_W-1:0]  pos_q, pos_d;
    logic              valid_q, valid_d;
    logic              match_q, match_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              str_we;
    logic [IDX_W-1:0]  str_waddr;
    logic              pat_we;
    logic [PIDX_W-1:0] pat_waddr;

    // Pattern decode results.
    logic              caret;
    logic              last_dollar;
    logic [PLEN_W-1:0] pre_lo, pre_hi;
    logic              pre_dollar;
    logic              pre_hit;

`ifdef SME_STAR_EN
    logic              star_found;
    logic [PLEN_W-1:0] star_pos;
    logic [PLEN_W-1:0] suf_lo, suf_hi;
    logic              suf_dollar;
    logic              suf_hit;
    logic [IDX_W-1:0]  pre_idx_q, pre_idx_d;
`endif

    // Checks pattern body pat[lo..hi-1] against the string starting at base, plus the
    // optional anchors. Body chars that would fall past the string end fail the position.
    function automatic logic seg_hit(input logic [LEN_W-1:0]  base,
                                     input logic [PLEN_W-1:0] lo,
                                     input logic [PLEN_W-1:0] hi,
                                     input logic              need_caret,
                                     input logic              need_dollar);
        logic             ok;
        logic [LEN_W-1:0] k;
        logic [LEN_W-1:0] kend;
        logic [LEN_W-1:0] bm1;
        ok = 1'b1;
        for (int m = 0; m < PAT_DEPTH; m++) begin
            if (PLEN_W'(m) >= lo && PLEN_W'(m) < hi) begin
                k = base + LEN_W'(m) - LEN_W'(lo);
                if (k >= str_len_q) begin
                    ok = 1'b0;
                end else if (pat_q[PIDX_W'(m)] != CH_DOT &&
                             pat_q[PIDX_W'(m)] != str_q[k[IDX_W-1:0]]) begin
                    ok = 1'b0;
                end
            end
        end
        bm1 = base - LEN_W'(1);
        if (need_caret && base != '0 && str_q[bm1[IDX_W-1:0]] != CH_SPACE) begin
            ok = 1'b0;
        end
        kend = base + LEN_W'(hi) - LEN_W'(lo);
        if (need_dollar && kend != str_len_q &&
            (kend > str_len_q || str_q[kend[IDX_W-1:0]] != CH_SPACE)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Pattern decode: anchors, optional star split and segment bounds.
    always_comb begin
        caret       = (pat_len_q != '0) && (pat_q[0] == CH_CARET);
        last_dollar = 1'b0;
        for (int m = 0; m < PAT_DEPTH; m++) begin
            if (PLEN_W'(m) + PLEN_W'(1) == pat_len_q && pat_q[PIDX_W'(m)] == CH_DOLLAR) begin
                last_dollar = 1'b1;
            end
        end
        pre_lo     = PLEN_W'(caret);
        pre_hi     = pat_len_q - PLEN_W'(last_dollar);
        pre_dollar = last_dollar;
`ifdef SME_STAR_EN
        star_found = 1'b0;
        star_pos   = '0;
        // Descending so the first '*' wins.
        for (int m = PAT_DEPTH - 1; m >= 0; m--) begin
            if (PLEN_W'(m) < pat_len_q && pat_q[PIDX_W'(m)] == CH_STAR) begin
                star_found = 1'b1;
                star_pos   = PLEN_W'(m);
            end
        end
        suf_lo     = '0;
        suf_hi     = '0;
        suf_dollar = 1'b0;
        if (star_found) begin
            pre_hi     = star_pos;
            pre_dollar = 1'b0;
            suf_lo     = star_pos + PLEN_W'(1);
            suf_hi     = pat_len_q - PLEN_W'(last_dollar);
            suf_dollar = last_dollar;
        end
`endif
    end

    // Segment matchers share pos_q: it holds p in SCAN and q in SCAN_SUF.
    always_comb begin
        pre_hit = seg_hit(pos_q, pre_lo, pre_hi, caret, pre_dollar);
`ifdef SME_STAR_EN
        suf_hit = seg_hit(pos_q, suf_lo, suf_hi, 1'b0, suf_dollar);
`endif
    end

    // Next-state, load control and result capture.
    always_comb begin
        state_d   = state_q;
        str_len_d = str_len_q;
        pat_len_d = pat_len_q;
        pos_d     = pos_q;
        valid_d   = 1'b0;
        match_d   = match_q;
        idx_d     = idx_q;
        str_we    = 1'b0;
        str_waddr = str_len_q[IDX_W-1:0];
        pat_we    = 1'b0;
        pat_waddr = pat_len_q[PIDX_W-1:0];
`ifdef SME_STAR_EN
        pre_idx_d = pre_idx_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (isstring) begin
                    str_we    = 1'b1;
                    str_waddr = '0;
                    str_len_d = LEN_W'(1);
                    state_d   = StLoadStr;
                end else if (ispattern) begin
                    pat_we    = 1'b1;
                    pat_waddr = '0;
                    pat_len_d = PLEN_W'(1);
                    state_d   = StLoadPat;
                end
            end
            StLoadStr: begin
                if (isstring) begin
                    if (str_len_q < LEN_W'(STR_DEPTH)) begin
                        str_we    = 1'b1;
                        str_len_d = str_len_q + LEN_W'(1);
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StLoadPat: begin
                if (ispattern) begin
                    if (pat_len_q < PLEN_W'(PAT_DEPTH)) begin
                        pat_we    = 1'b1;
                        pat_len_d = pat_len_q + PLEN_W'(1);
                    end
                end else begin
                    pos_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (str_len_q == '0 || pat_len_q == '0) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    match_d = 1'b0;
                    idx_d   = '0;
                end else if (pre_hit) begin
`ifdef SME_STAR_EN
                    if (star_found) begin
                        pre_idx_d = pos_q[IDX_W-1:0];
                        pos_d     = pos_q + LEN_W'(pre_hi - pre_lo);
                        state_d   = StScanSuf;
                    end else begin
                        state_d = StDone;
                        valid_d = 1'b1;
                        match_d = 1'b1;
                        idx_d   = pos_q[IDX_W-1:0];
                    end
`else
                    state_d = StDone;
                    valid_d = 1'b1;
                    match_d = 1'b1;
                    idx_d   = pos_q[IDX_W-1:0];
`endif
                end else if (pos_q + LEN_W'(1) == str_len_q) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    match_d = 1'b0;
                    idx_d   = '0;
                end else begin
                    pos_d = pos_q + LEN_W'(1);
                end
            end
`ifdef SME_STAR_EN
            StScanSuf: begin
                // q runs up to str_len inclusive so an empty or '$'-only suffix can hit.
                if (suf_hit) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    match_d = 1'b1;
                    idx_d   = pre_idx_q;
                end else if (pos_q >= str_len_q) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    match_d = 1'b0;
                    idx_d   = '0;
                end else begin
                    pos_d = pos_q + LEN_W'(1);
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and result registers; reset aborts any scan without a strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            str_len_q <= '0;
            pat_len_q <= '0;
            pos_q     <= '0;
            valid_q   <= 1'b0;
            match_q   <= 1'b0;
            idx_q     <= '0;
`ifdef SME_STAR_EN
            pre_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            str_len_q <= str_len_d;
            pat_len_q <= pat_len_d;
            pos_q     <= pos_d;
            valid_q   <= valid_d;
            match_q   <= match_d;
            idx_q     <= idx_d;
`ifdef SME_STAR_EN
            pre_idx_q <= pre_idx_d;
`endif
        end
    end

    // Character storage; contents are only meaningful below the stored lengths.
    always_ff @(posedge clk) begin
        if (str_we) begin
            str_q[str_waddr] <= chardata;
        end
        if (pat_we) begin
            pat_q[pat_waddr] <= chardata;
        end
    end

    // Busy covers every state in which inputs are ignored.
    always_comb begin
        busy = (state_q == StScan) || (state_q == StDone);
`ifdef SME_STAR_EN
        if (state_q == StScanSuf) begin
            busy = 1'b1;
        end
`endif
    end

    assign valid       = valid_q;
    assign match       = match_q;
    assign match_index = idx_q;

endmodule

// File: tb/tb_sme_param.sv
// tb_sme_param: directed self-checking bench for sme_param.
// Latency is counted in rising edges after e0, the edge that samples the last pattern char.
module tb_sme_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       busy;
    logic       valid;
    logic       match;
    logic [4:0] match_index;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sme_param dut (
        .clk         (clk),
        .reset       (reset),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .busy        (busy),
        .valid       (valid),
        .match       (match),
        .match_index (match_index)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            isstring  = 1'b1;
            ispattern = 1'b0;
            chardata  = s[i];
        end
        @(negedge clk);
        isstring = 1'b0;
        chardata = 8'h00;
    endtask

    task automatic send_pat(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            ispattern = 1'b1;
            chardata  = s[i];
        end
        @(posedge clk);
        @(negedge clk);
        ispattern = 1'b0;
        chardata  = 8'h00;
    endtask

    // Returns the edge count after e0 at which valid is seen, or -1 on timeout.
    // If poke > 0, drives ispattern high for two edges starting at that count.
    task automatic wait_valid(input int poke, output int lat);
        lat = -1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            #1;
            if (poke > 0 && c == poke) begin
                ispattern = 1'b1;
                chardata  = "k";
            end
            if (poke > 0 && c == poke + 2) begin
                ispattern = 1'b0;
                chardata  = 8'h00;
            end
            if (valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input string pat, input logic exp_m,
                       input int exp_idx, input int exp_lat, input int poke);
        int lat;
        send_pat(pat);
        wait_valid(poke, lat);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " match"}, {31'd0, match}, {31'd0, exp_m});
        chk({tag, " index"}, {27'd0, match_index}, exp_idx);
        @(posedge clk);
        #1;
        chk({tag, " valid width"}, {31'd0, valid}, 32'd0);
        chk({tag, " busy after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        string s;
        int    seen;

        reset     = 1'b0;
        isstring  = 1'b0;
        ispattern = 1'b0;
        chardata  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", {31'd0, valid}, 32'd0);
        chk("reset match", {31'd0, match}, 32'd0);
        chk("reset index", {27'd0, match_index}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // T1 / T2: one string, several patterns.
        load_str("abc def");
        run("T1 def", "def", 1'b1, 4, 6, 0);
        run("T2 ^de", "^de", 1'b1, 4, 6, 0);
        run("T2 c$", "c$", 1'b1, 2, 4, 0);
        run("T2 ^b", "^b", 1'b0, 0, 8, 0);
        run("T2 f$", "f$", 1'b1, 6, 8, 0);
        run("T2 x", "x", 1'b0, 0, 8, 0);

        // T3: string saturates at 32 chars, pattern at 8 chars.
        s = "";
        for (int i = 0; i < 40; i++) begin
            if (i == 33) s = {s, "x"};
            else if (i == 34) s = {s, "y"};
            else if (i == 35) s = {s, "z"};
            else s = {s, "a"};
        end
        load_str(s);
        run("T3 xyz", "xyz", 1'b0, 0, 33, 0);
        run("T3 a$", "a$", 1'b1, 31, 33, 0);
        run("T3 trunc", "aaaaaaaaxy", 1'b1, 0, 2, 0);

        // T4: reset mid-scan.
        load_str("abc def");
        send_pat("x");
        repeat (3) @(posedge clk);
        #1;
        chk("T4 busy mid-scan", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("T4 reset valid", {31'd0, valid}, 32'd0);
        chk("T4 reset match", {31'd0, match}, 32'd0);
        chk("T4 reset index", {27'd0, match_index}, 32'd0);
        chk("T4 reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) seen = 1;
        end
        chk("T4 no pulse after reset", seen, 0);
        run("T4 empty string", "a", 1'b0, 0, 2, 0);
        load_str("xay");
        run("T4 reload", "a", 1'b1, 1, 3, 0);

        // T5: isstring wins over ispattern; ispattern while busy is ignored.
        @(negedge clk);
        isstring  = 1'b1;
        ispattern = 1'b1;
        chardata  = "k";
        load_str("abcdefg");
        run("T5 priority+busy", "g", 1'b1, 7, 9, 3);
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1 || busy === 1'b1) seen = 1;
        end
        chk("T5 idle after", seen, 0);

        // T6: star handling.
        load_str("abc def");
`ifdef SME_STAR_EN
        run("T6 b*e", "b*e", 1'b1, 1, 7, 0);
        run("T6 e*a", "e*a", 1'b0, 0, 9, 0);
        run("T6 ^a*f$", "^a*f$", 1'b1, 0, 8, 0);
        run("T6 d*", "d*", 1'b1, 4, 7, 0);
`else
        run("T6 b*e literal", "b*e", 1'b0, 0, 8, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
